// File: rtl/tx_fifo_packet_reader.sv
// Streams one packet out of a transactional FIFO, committing on ack and rolling back on nak.
// Optional WAIT_ACK timeout is enabled with `define TX_READER_TIMEOUT_EN.
module tx_fifo_packet_reader #(
   parameter int DATA_WID       = 8,
   parameter int MAX_RETRIES    = 3,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                dataAvailable_i,
   input  logic [DATA_WID-1:0] data_i,
   input  logic                isLast_i,
   output logic                popData_o,
   output logic                popTransDone_o,
   output logic                popTransSuccess_o,
   output logic                txValid_o,
   input  logic                txReady_i,
   output logic [DATA_WID-1:0] txData_o,
   output logic                txLast_o,
   input  logic                ack_i,
   input  logic                nak_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                dropped_o,
   output logic [15:0]         byteCnt_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_WAIT_ACK,
      S_COMMIT,
      S_ROLLBACK
   } state_t;

   localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_retry;
   logic [3:0]  w_retryInc;
   logic        r_drop;
   logic [15:0] r_byteCnt;
   logic        w_pop;
   logic        w_fail;
   logic        w_tmo;

   assign w_retryInc = r_retry + 4'd1;
   assign txData_o   = data_i;
   assign busy_o     = (r_state != S_IDLE);
   assign byteCnt_o  = r_byteCnt;
   assign popData_o  = w_pop;

   always_comb begin
      w_next            = r_state;
      w_pop             = 1'b0;
      w_fail            = 1'b0;
      txValid_o         = 1'b0;
      txLast_o          = 1'b0;
      popTransDone_o    = 1'b0;
      popTransSuccess_o = 1'b0;
      done_o            = 1'b0;
      dropped_o         = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start_i && dataAvailable_i) w_next = S_STREAM;
         end
         S_STREAM: begin
            txValid_o = dataAvailable_i;
            txLast_o  = isLast_i;
            w_pop     = dataAvailable_i && txReady_i;
            if (w_pop && isLast_i) w_next = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            // ack wins over a simultaneous nak
            if (ack_i) begin
               w_next = S_COMMIT;
            end else if (nak_i || w_tmo) begin
               w_fail = 1'b1;
               w_next = (w_retryInc == MAX_R) ? S_COMMIT : S_ROLLBACK;
            end
         end
         S_COMMIT: begin
            popTransDone_o    = 1'b1;
            popTransSuccess_o = 1'b1;
            done_o            = !r_drop;
            dropped_o         = r_drop;
            w_next            = S_IDLE;
         end
         S_ROLLBACK: begin
            popTransDone_o = 1'b1;
            w_next         = S_STREAM;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_retry   <= 4'd0;
         r_drop    <= 1'b0;
         r_byteCnt <= 16'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_COMMIT) begin
            r_retry <= 4'd0;
            r_drop  <= 1'b0;
         end else if (w_fail) begin
            r_retry <= w_retryInc;
            r_drop  <= (w_retryInc == MAX_R);
         end
         if (w_next == S_STREAM &&
             (r_state == S_IDLE || r_state == S_ROLLBACK)) begin
            r_byteCnt <= 16'd0;
         end else if (w_pop && r_byteCnt != 16'hFFFF) begin
            r_byteCnt <= r_byteCnt + 16'd1;
         end
      end
   end

`ifdef TX_READER_TIMEOUT_EN
   logic [15:0] r_tmoCnt;

   assign w_tmo = (r_tmoCnt == 16'(TIMEOUT_CYCLES - 1));

   // held at zero outside WAIT_ACK so it starts from zero on entry
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_tmoCnt <= 16'd0;
      end else if (r_state != S_WAIT_ACK) begin
         r_tmoCnt <= 16'd0;
      end else begin
         r_tmoCnt <= r_tmoCnt + 16'd1;
      end
   end
`else
   // TIMEOUT_CYCLES is never 0, so WAIT_ACK never expires
   assign w_tmo = (TIMEOUT_CYCLES == 0);
`endif

endmodule
